// File: rtl/mem_arbiter_if.sv
// Pipeline-side request/completion signals and the byte-wide RAM port of the memory arbiter.
// The arbiter connects through the slave modport; requesters and the RAM model use master.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 17
);
  logic                  if_req;
  logic [31:0]           if_addr;
  logic                  if_fin;
  logic [31:0]           if_data;
  logic [1:0]            memctl_op;
  logic [1:0]            memctl_len;
  logic [31:0]           memctl_addr;
  logic [31:0]           memctl_data;
  logic                  memctl_fin;
  logic [31:0]           memctl_out;
  logic [7:0]            ram_din;
  logic [7:0]            ram_dout;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic                  ram_wr;

  modport slave (
    input  if_req, if_addr, memctl_op, memctl_len, memctl_addr, memctl_data, ram_din,
    output if_fin, if_data, memctl_fin, memctl_out, ram_dout, ram_a, ram_wr
  );

  modport master (
    output if_req, if_addr, memctl_op, memctl_len, memctl_addr, memctl_data, ram_din,
    input  if_fin, if_data, memctl_fin, memctl_out, ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide synchronous RAM port between instruction fetch and the MEM stage,
// splitting 1/2/4-byte loads and stores into little-endian byte accesses.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic clk_in,
  input  logic rstn_in,
  input  logic rdy_in,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state_q;
  logic                  owner_mem_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           data_q;
  logic [31:0]           result_q;
  logic [2:0]            n_q;
  logic [2:0]            idx_q;
  logic                  if_fin_q;
  logic                  mem_fin_q;
  logic [31:0]           if_data_q;
  logic [31:0]           mem_out_q;

  logic                  mem_valid;
  logic [2:0]            mem_n;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]           assembled;

  assign mem_valid = ((bus.memctl_op == 2'd1) || (bus.memctl_op == 2'd2)) && (bus.memctl_len != 2'd3);
  assign mem_n     = (bus.memctl_len == 2'd0) ? 3'd1 : (bus.memctl_len == 2'd1) ? 3'd2 : 3'd4;
  // Truncating after the add gives the same low bits as the full 32-bit modulo sum.
  assign cur_addr  = base_q + ADDR_WIDTH'(idx_q);

  // Byte read at idx-1 arrives while idx is current; merge it into its lane.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign assembled[8*gi +: 8] = (idx_q == 3'(gi + 1)) ? bus.ram_din : result_q[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q     <= IDLE;
      owner_mem_q <= 1'b0;
      base_q      <= '0;
      data_q      <= '0;
      result_q    <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      if_fin_q    <= 1'b0;
      mem_fin_q   <= 1'b0;
      if_data_q   <= '0;
      mem_out_q   <= '0;
    end else if (rdy_in) begin
      if_fin_q  <= 1'b0;
      mem_fin_q <= 1'b0;
      case (state_q)
        IDLE: begin
          idx_q    <= '0;
          result_q <= '0;
          if (mem_valid) begin
            owner_mem_q <= 1'b1;
            base_q      <= bus.memctl_addr[ADDR_WIDTH-1:0];
            data_q      <= bus.memctl_data;
            n_q         <= mem_n;
            state_q     <= (bus.memctl_op == 2'd2) ? WRITE : READ;
          end else if (bus.if_req) begin
            owner_mem_q <= 1'b0;
            base_q      <= bus.if_addr[ADDR_WIDTH-1:0];
            data_q      <= '0;
            n_q         <= 3'd4;
            state_q     <= READ;
          end
        end
        READ: begin
          if (idx_q != 3'd0) result_q <= assembled;
          if (idx_q == n_q) begin
            state_q <= DONE;
            if (owner_mem_q) begin
              mem_out_q <= assembled;
              mem_fin_q <= 1'b1;
            end else begin
              if_data_q <= assembled;
              if_fin_q  <= 1'b1;
            end
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        WRITE: begin
          if (idx_q == n_q - 3'd1) begin
            state_q   <= DONE;
            mem_fin_q <= owner_mem_q;
            if_fin_q  <= ~owner_mem_q;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM strobes are forced off while paused so a frozen WRITE cannot repeat.
  assign bus.ram_wr     = (state_q == WRITE) && rdy_in;
  assign bus.ram_a      = (((state_q == READ) && (idx_q < n_q)) || (state_q == WRITE)) ? cur_addr : '0;
  assign bus.ram_dout   = (state_q == WRITE) ? data_q[{idx_q[1:0], 3'b000} +: 8] : 8'h00;
  assign bus.if_fin     = if_fin_q;
  assign bus.if_data    = if_data_q;
  assign bus.memctl_fin = mem_fin_q;
  assign bus.memctl_out = mem_out_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a byte RAM model on the bus and cycle-exact checks
// of grants, RAM strobes, completion pulses and assembled data.
module tb_mem_arbiter;
  localparam int AW = 17;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rdy = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk_in (clk),
    .rstn_in(rstn),
    .rdy_in (rdy),
    .bus    (bus)
  );

  logic [7:0]    mem [0:(1<<AW)-1];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_a  = '0;
  logic [7:0]    pre_d  = '0;

  // Synchronous RAM, clock-enabled by rdy; preload writes share the same process.
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_a] <= pre_d;
    end else if (rdy) begin
      if (bus.ram_wr) mem[bus.ram_a] <= bus.ram_dout;
      bus.ram_din <= mem[bus.ram_a];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_en = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic mem_req(input logic [1:0] op, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] data);
    bus.memctl_op   = op;
    bus.memctl_len  = len;
    bus.memctl_addr = addr;
    bus.memctl_data = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    mem_req(2'd0, 2'd0, 32'h0, 32'h0);

    poke(17'h00100, 8'h11); poke(17'h00101, 8'h22);
    poke(17'h00102, 8'h33); poke(17'h00103, 8'h44);
    poke(17'h00200, 8'hA5);
    poke(17'h00300, 8'h01); poke(17'h00301, 8'h02);
    poke(17'h00302, 8'h03); poke(17'h00303, 8'h04);
    poke(17'h00400, 8'hDE); poke(17'h00401, 8'hAD);
    poke(17'h00402, 8'hBE); poke(17'h00403, 8'hEF);
    poke(17'h00501, 8'h77);

    check("rst ram_wr", 32'(bus.ram_wr), 32'd0);
    check("rst ram_a", 32'(bus.ram_a), 32'd0);
    check("rst ram_dout", 32'(bus.ram_dout), 32'd0);
    check("rst fins", {30'd0, bus.if_fin, bus.memctl_fin}, 32'd0);
    check("rst data", bus.if_data | bus.memctl_out, 32'd0);
    @(negedge clk) rstn = 1'b1;
    step();

    // LW from MEM at 0x100
    mem_req(2'd1, 2'd2, 32'h100, 32'h0);
    check("t1 fin c0", 32'(bus.memctl_fin), 32'd0);
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 1) bus.memctl_op = 2'd0;
      check($sformatf("t1 wr c%0d", c), 32'(bus.ram_wr), 32'd0);
      if (c <= 4) check($sformatf("t1 ram_a c%0d", c), 32'(bus.ram_a), 32'h100 + 32'(c - 1));
      check($sformatf("t1 fin c%0d", c), 32'(bus.memctl_fin), 32'(c == 6));
      if (c == 6) check("t1 memctl_out", bus.memctl_out, 32'h44332211);
    end

    // SH across the top of the address space
    mem_req(2'd2, 2'd1, 32'h1FFFF, 32'hABCD1234);
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 1) bus.memctl_op = 2'd0;
      if (c == 1) check("t2 c1 a/dout/wr", {7'd0, bus.ram_a, bus.ram_dout}, {7'd0, 17'h1FFFF, 8'h34});
      if (c == 2) check("t2 c2 a/dout/wr", {7'd0, bus.ram_a, bus.ram_dout}, {7'd0, 17'h00000, 8'h12});
      if (c <= 2) check($sformatf("t2 wr c%0d", c), 32'(bus.ram_wr), 32'd1);
      check($sformatf("t2 fin c%0d", c), 32'(bus.memctl_fin), 32'(c == 3));
    end
    check("t2 mem[1FFFF]", 32'(mem[17'h1FFFF]), 32'h34);
    check("t2 mem[0]", 32'(mem[17'h00000]), 32'h12);

    // IF and MEM LB together: MEM first, IF granted in the following IDLE
    mem_req(2'd1, 2'd0, 32'h200, 32'h0);
    bus.if_req = 1'b1;
    bus.if_addr = 32'h300;
    for (int c = 1; c <= 11; c++) begin
      step();
      if (c == 1) bus.memctl_op = 2'd0;
      if (c == 5) bus.if_req = 1'b0;
      check($sformatf("t3 mfin c%0d", c), 32'(bus.memctl_fin), 32'(c == 3));
      check($sformatf("t3 ifin c%0d", c), 32'(bus.if_fin), 32'(c == 10));
      if (c == 3) check("t3 memctl_out", bus.memctl_out, 32'h000000A5);
      if (c == 5) check("t3 ram_a c5", 32'(bus.ram_a), 32'h300);
      if (c == 10) check("t3 if_data", bus.if_data, 32'h04030201);
    end

    // IF load paused for 3 cycles
    bus.if_req = 1'b1;
    bus.if_addr = 32'h400;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) bus.if_req = 1'b0;
      if (c == 2) rdy = 1'b0;
      if (c == 5) rdy = 1'b1;
      if (c >= 2 && c <= 5) check($sformatf("t4 ram_a c%0d", c), 32'(bus.ram_a), 32'h401);
      check($sformatf("t4 ifin c%0d", c), 32'(bus.if_fin), 32'(c == 9));
      if (c == 9) check("t4 if_data", bus.if_data, 32'hEFBEADDE);
    end

    // Reset mid-SW
    mem_req(2'd2, 2'd2, 32'h500, 32'h11223344);
    step();
    bus.memctl_op = 2'd0;
    step();
    check("t5 wr before rst", 32'(bus.ram_wr), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("t5 wr after rst", 32'(bus.ram_wr), 32'd0);
    check("t5 a/dout after rst", {7'd0, bus.ram_a, bus.ram_dout}, 32'd0);
    check("t5 memctl_out cleared", bus.memctl_out, 32'd0);
    @(negedge clk) rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("t5 no fin %0d", c), {30'd0, bus.if_fin, bus.memctl_fin}, 32'd0);
    end
    check("t5 mem[500]", 32'(mem[17'h00500]), 32'h44);
    check("t5 mem[501] untouched", 32'(mem[17'h00501]), 32'h77);
    mem_req(2'd1, 2'd0, 32'h200, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 1) bus.memctl_op = 2'd0;
      check($sformatf("t5 lb fin c%0d", c), 32'(bus.memctl_fin), 32'(c == 3));
      if (c == 3) check("t5 lb out", bus.memctl_out, 32'h000000A5);
    end

    // Illegal requests are ignored
    for (int k = 0; k < 2; k++) begin
      if (k == 0) mem_req(2'd3, 2'd2, 32'h100, 32'hFFFFFFFF);
      else        mem_req(2'd1, 2'd3, 32'h100, 32'hFFFFFFFF);
      for (int c = 1; c <= 7; c++) begin
        step();
        check($sformatf("t6.%0d idle c%0d", k, c),
              {7'd0, bus.ram_a, bus.ram_wr, bus.if_fin, bus.memctl_fin, 5'd0}, 32'd0);
      end
    end
    mem_req(2'd0, 2'd0, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single byte-wide synchronous RAM port and shares it between the instruction-fetch requester (IF) and the MEM stage.
- Sequences each 1/2/4-byte load or store as a string of byte accesses, little-endian.
- Returns a one-cycle completion pulse, plus assembled data for loads, to the requester that owns the transaction.
- Sits between the pipeline (IF, MEM) and the RAM/IO bus at CPU top level.

Parameters:
ADDR_WIDTH, 17, width of ram_a; low bits of the 32-bit byte address.

Ports:
clk_in  input  1  clock; all state updates on rising edge
rstn_in  input  1  asynchronous active-low reset
rdy_in  input  1  global enable; low freezes all registers (RAM clock-enable is tied to rdy_in at top level)
if_req  input  1  IF requests a 4-byte instruction load
if_addr  input  32  IF byte address
if_fin  output  1  one-cycle pulse: IF load complete
if_data  output  32  assembled instruction word, valid while if_fin=1, held afterwards
memctl_op  input  2  MEM request: 0=NOP, 1=LOAD, 2=SAVE, 3=illegal (treated as NOP)
memctl_len  input  2  0=byte, 1=half, 2=word, 3=illegal (request ignored)
memctl_addr  input  32  MEM byte address
memctl_data  input  32  store data; low len bytes used
memctl_fin  output  1  one-cycle pulse: MEM transaction complete
memctl_out  output  32  load result, zero-extended, valid while memctl_fin=1, held afterwards
ram_din  input  8  RAM read data; valid one enabled cycle after its address
ram_dout  output  8  RAM write data
ram_a  output  ADDR_WIDTH  RAM byte address
ram_wr  output  1  1=write, 0=read

Behaviour:
- Reset (rstn_in=0, any time including mid-transaction):
  - State -> IDLE; internal counters and latched request registers cleared.
  - if_fin=0, if_data=0, memctl_fin=0, memctl_out=0, ram_wr=0, ram_a=0, ram_dout=0.
  - Any in-flight transaction is abandoned with no fin.
- States: IDLE, READ, WRITE, DONE. The RAM outputs are decoded from state and registers only.
- IDLE:
  - RAM idle: ram_wr=0, ram_a=0.
  - Sample requesters. MEM has fixed priority: valid memctl_op (1 or 2) with memctl_len<=2 wins over if_req.
  - On grant, latch owner, op, base address, store data and byte count N (1/2/4; IF always 4); clear idx; go to READ or WRITE.
  - With no valid request, stay in IDLE.
- Non-preemptive: a granted transaction always runs to completion. Requester inputs are ignored until the next IDLE.
- READ (N+1 cycles, idx=0..N):
  - When idx<N, drive ram_a=(base+idx)[ADDR_WIDTH-1:0] with ram_wr=0.
  - When idx>=1, capture ram_din into byte lane idx-1 of the result register; lanes >=N stay 0.
  - At idx=N, go to DONE.
- WRITE (N cycles, idx=0..N-1):
  - Drive ram_wr=1, ram_a=base+idx, ram_dout=data[8*idx+7:8*idx].
  - After idx=N-1, go to DONE.
- DONE (1 cycle):
  - Pulse the owner's fin (registered output); the other fin stays 0.
  - For a load, copy the result into the owner's data output.
  - Return to IDLE; the next request is sampled in that IDLE cycle.
- Latency from the request first visible in IDLE (cycle 0) to fin:
  - LB: cycle 3. LH: cycle 4. LW/IF: cycle 6.
  - SB: cycle 2. SH: cycle 3. SW: cycle 5.
- Address arithmetic is 32-bit modulo 2^32 and then truncated to ADDR_WIDTH; a wrap past the top maps to address 0.
- rdy_in=0: no register changes. RAM outputs hold their values, except that ram_wr is forced to 0 while paused. Resuming continues exactly where the transaction stopped.
- if_req dropped mid-transaction (flush): the transaction still completes and if_fin still pulses; IF discards the result.
- A fin output is never high for two consecutive cycles, and if_fin and memctl_fin are never high together.

Test Plan:
1. Reset, then LW from MEM at 0x100 with RAM bytes 0x11,0x22,0x33,0x44 -> ram_a sequence 0x100..0x103 in cycles 1-4; memctl_fin=1 only in cycle 6; memctl_out=0x44332211; ram_wr never 1.
2. SH from MEM, addr 0x1FFFF, data 0xABCD1234 -> cycle 1: ram_a=0x1FFFF, ram_dout=0x34, ram_wr=1; cycle 2: ram_a=0x00000 (wrap), ram_dout=0x12, ram_wr=1; memctl_fin pulses in cycle 3.
3. if_req and a MEM LB held together from cycle 0 -> MEM served first; memctl_fin in cycle 3, memctl_out upper 24 bits 0. IF granted in the following IDLE cycle (4); if_fin pulses in cycle 10.
4. rdy_in low for 3 cycles in the middle of an IF word load -> all outputs and state frozen; the result word is unchanged versus an unpaused run; if_fin is delayed by exactly 3 cycles.
5. rstn_in pulsed low mid-WRITE of SW -> ram_wr drops to 0 asynchronously; no fin pulse; the next request starts cleanly from IDLE.
6. memctl_op=3 or memctl_len=3 with if_req=0 -> stays in IDLE; no RAM activity; no fin.
